// File: rtl/gpmc_sync_ctrl.sv
// GPMC synchronous slave: decodes the multiplexed GPMC bus into a
// single-outstanding internal memory request with wait and timeout handling.
module gpmc_sync_ctrl #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned WAIT_MAX     = 15,
    parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
    input  logic              GPMC_CLK,
    input  logic              RST,
    input  logic [15:0]       GPMC_AD_I,
    output logic [15:0]       GPMC_AD_O,
    output logic              GPMC_AD_OE,
    input  logic              GPMC_CS,
    input  logic              GPMC_ADV,
    input  logic              GPMC_OE,
    input  logic              GPMC_WE,
    input  logic              GPMC_BE0,
    input  logic              GPMC_BE1,
    output logic              GPMC_WAIT,
    output logic              MEM_REQ,
    output logic              MEM_WR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    output logic [1:0]        MEM_BE,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_RDATA,
    output logic              ERR_TIMEOUT,
    output logic              ERR_PROTO
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR_CAP,
        RD_REQ,
        WR_REQ,
        RD_DATA,
        FLUSH
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [1:0]        be_q, be_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic              to_q, to_d;
    logic              pe_q, pe_d;
    logic              busy;
    logic              gone;
    logic              is_rd;

    always_ff @(posedge GPMC_CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            to_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            to_q    <= to_d;
            pe_q    <= pe_d;
        end
    end

    assign busy  = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign is_rd = (state_q == RD_REQ);
    // A host that released CS mid-request must not see the pad driven later
    assign gone  = drop_q || GPMC_CS;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        to_d    = 1'b0;
        pe_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!GPMC_CS && !GPMC_ADV) begin
                    addr_d  = GPMC_AD_I[ADDR_W-1:0];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (GPMC_CS) begin
                    state_d = IDLE;
                end else if (!GPMC_ADV) begin
                    addr_d = GPMC_AD_I[ADDR_W-1:0];
                end else if (!GPMC_OE && !GPMC_WE) begin
                    pe_d    = 1'b1;
                    state_d = IDLE;
                end else if (!GPMC_OE) begin
                    be_d    = 2'b11;
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    state_d = RD_REQ;
                end else if (!GPMC_WE) begin
                    state_d = WR_CAP;
                end
            end
            WR_CAP: begin
                if (GPMC_CS) begin
                    state_d = IDLE;
                end else begin
                    wdata_d = GPMC_AD_I;
                    be_d    = ~{GPMC_BE1, GPMC_BE0};
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    state_d = WR_REQ;
                end
            end
            RD_REQ, WR_REQ: begin
                drop_d = gone;
                if (MEM_ACK) begin
                    if (is_rd) rdata_d = MEM_RDATA;
                    if (gone)       state_d = IDLE;
                    else if (is_rd) state_d = RD_DATA;
                    else            state_d = FLUSH;
                end else if (cnt_q == CNT_LAST) begin
                    to_d  = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                    if (is_rd) rdata_d = TIMEOUT_DATA;
                    if (gone)       state_d = IDLE;
                    else if (is_rd) state_d = RD_DATA;
                    else            state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_DATA: begin
                if (GPMC_CS || GPMC_OE) state_d = FLUSH;
            end
            FLUSH: begin
                if (GPMC_CS) begin
                    state_d = IDLE;
                end else if (!GPMC_ADV) begin
                    addr_d  = GPMC_AD_I[ADDR_W-1:0];
                    state_d = ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign MEM_REQ     = busy;
    assign MEM_WR      = (state_q == WR_REQ);
    assign GPMC_WAIT   = busy;
    assign MEM_ADDR    = addr_q;
    assign MEM_WDATA   = wdata_q;
    assign MEM_BE      = be_q;
    assign GPMC_AD_O   = rdata_q;
    assign GPMC_AD_OE  = (state_q == RD_DATA) && !GPMC_CS && !GPMC_OE;
    assign ERR_TIMEOUT = to_q;
    assign ERR_PROTO   = pe_q;

endmodule

// File: tb/tb_gpmc_sync_ctrl.sv
// Bench for gpmc_sync_ctrl: table vectors, random transactions against a
// transaction-level model, and hand sequences for protocol/reset corners.
module tb_gpmc_sync_ctrl;

    localparam int WMAX = 15;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] ad_i, ad_o, wdata, rdata_in, maddr;
    logic        ad_oe, cs, adv, oe, we, be0, be1;
    logic        wait_o, req, wr, ack, eto, epr;
    logic [1:0]  mbe;

    int checks = 0;
    int errors = 0;
    int n_to = 0;
    int n_pe = 0;

    gpmc_sync_ctrl dut (
        .GPMC_CLK   (clk),
        .RST        (rst),
        .GPMC_AD_I  (ad_i),
        .GPMC_AD_O  (ad_o),
        .GPMC_AD_OE (ad_oe),
        .GPMC_CS    (cs),
        .GPMC_ADV   (adv),
        .GPMC_OE    (oe),
        .GPMC_WE    (we),
        .GPMC_BE0   (be0),
        .GPMC_BE1   (be1),
        .GPMC_WAIT  (wait_o),
        .MEM_REQ    (req),
        .MEM_WR     (wr),
        .MEM_ADDR   (maddr),
        .MEM_WDATA  (wdata),
        .MEM_BE     (mbe),
        .MEM_ACK    (ack),
        .MEM_RDATA  (rdata_in),
        .ERR_TIMEOUT(eto),
        .ERR_PROTO  (epr)
    );

    always @(negedge clk) begin
        if (eto) n_to <= n_to + 1;
        if (epr) n_pe <= n_pe + 1;
    end

    typedef struct {
        bit          wr;
        bit          cs_drop;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  be_n;
        int          lat;
        int          exp_req;
        logic [15:0] exp_rd;
        logic [1:0]  exp_be;
        bit          exp_to;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level expectation: lat is the REQ cycle carrying ACK, 0 = never
    function automatic vec_t model(input bit w, input bit drop,
                                   input logic [15:0] a, input logic [15:0] d,
                                   input logic [1:0] ben, input int lat);
        vec_t v;
        bit   to;
        to = (lat < 1) || (lat > WMAX);
        v.wr      = w;
        v.cs_drop = drop;
        v.addr    = a;
        v.data    = d;
        v.be_n    = ben;
        v.lat     = lat;
        v.exp_req = to ? WMAX : lat;
        v.exp_rd  = (to && !w) ? 16'hDEAD : d;
        v.exp_be  = w ? ~ben : 2'b11;
        v.exp_to  = to;
        return v;
    endfunction

    task automatic do_txn(input vec_t v);
        int n = 0;
        int bad = 0;
        int oe_bad = 0;
        int to0;
        int pe0;
        bit fin = 1'b0;
        to0 = n_to;
        pe0 = n_pe;
        @(negedge clk);
        cs = 1'b0; adv = 1'b0; ad_i = v.addr;
        @(negedge clk);
        chk("addr_latch", 32'(maddr), 32'(v.addr));
        adv = 1'b1; ad_i = v.data; {be1, be0} = v.be_n;
        if (v.wr) we = 1'b0;
        else      oe = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            ack = 1'b0;
            if (ad_oe && (req || v.wr || v.cs_drop)) oe_bad++;
            if (req) begin
                n++;
                if (wr !== v.wr || maddr !== v.addr || mbe !== v.exp_be ||
                    wait_o !== 1'b1 || (v.wr && wdata !== v.exp_rd))
                    bad++;
                if (v.cs_drop && n == 1) cs = 1'b1;
                if (v.lat == n) begin
                    ack = 1'b1;
                    rdata_in = v.data;
                end
            end else if (n > 0) begin
                fin = 1'b1;
            end
        end
        chk("req_done", 32'(fin), 32'd1);
        chk("req_cycles", 32'(n), 32'(v.exp_req));
        chk("req_fields", 32'(bad), 32'd0);
        chk("wait_low", 32'(wait_o), 32'd0);
        if (v.exp_to) begin
            ack = 1'b1; rdata_in = 16'h1234;
            @(negedge clk);
            ack = 1'b0;
        end
        if (!v.wr && !v.cs_drop) begin
            chk("rd_data", 32'(ad_o), 32'(v.exp_rd));
            chk("rd_oe", 32'(ad_oe), 32'd1);
            @(negedge clk);
            chk("rd_hold", 32'(ad_o), 32'(v.exp_rd));
            chk("rd_hold_oe", 32'(ad_oe), 32'd1);
            cs = 1'b1;
            #1 chk("oe_cs_gate", 32'(ad_oe), 32'd0);
            cs = 1'b0;
            @(negedge clk);
            oe = 1'b1;
            @(negedge clk);
            chk("oe_release", 32'(ad_oe), 32'd0);
        end else if (v.cs_drop) begin
            cs = 1'b0;
            #1 chk("drop_idle", 32'(ad_oe), 32'd0);
        end
        oe = 1'b1; we = 1'b1; cs = 1'b1; adv = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("no_pad_drive", 32'(oe_bad), 32'd0);
        chk("to_pulses", 32'(n_to - to0), 32'(v.exp_to));
        chk("pe_pulses", 32'(n_pe - pe0), 32'd0);
    endtask

    initial begin
        int pe0;
        bit reqseen;
        rst = 1'b1; cs = 1'b1; adv = 1'b1; oe = 1'b1; we = 1'b1;
        be0 = 1'b1; be1 = 1'b1; ack = 1'b0; ad_i = '0; rdata_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_wait", 32'(wait_o), 32'd0);
        chk("rst_ad_oe", 32'(ad_oe), 32'd0);
        chk("rst_errs", 32'({eto, epr}), 32'd0);
        chk("rst_addr", 32'(maddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_be", 32'(mbe), 32'd0);
        chk("rst_ad_o", 32'(ad_o), 32'd0);
        rst = 1'b0;

        tbl[0] = '{1'b0, 1'b0, 16'h0123, 16'hBEEF, 2'b00, 3,  3,  16'hBEEF, 2'b11, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h0040, 16'hA5A5, 2'b10, 1,  1,  16'hA5A5, 2'b01, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 16'h1000, 16'h5555, 2'b00, 0,  15, 16'hDEAD, 2'b11, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 16'h0FFF, 16'h1234, 2'b11, 15, 15, 16'h1234, 2'b11, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 16'h2222, 16'h7777, 2'b01, 16, 15, 16'hDEAD, 2'b11, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0F0F, 2'b00, 0,  15, 16'h0F0F, 2'b11, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 16'h8001, 16'h1357, 2'b01, 15, 15, 16'h1357, 2'b10, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 16'h0040, 16'hC3C3, 2'b11, 2,  2,  16'hC3C3, 2'b00, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 16'h0ABC, 16'h9999, 2'b00, 4,  4,  16'h9999, 2'b11, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 2'b10, 1,  1,  16'h0000, 2'b11, 1'b0};
        for (int i = 0; i < 10; i++) do_txn(tbl[i]);

        pe0 = n_pe;
        reqseen = 1'b0;
        @(negedge clk);
        cs = 1'b0; adv = 1'b0; ad_i = 16'h0333;
        @(negedge clk);
        adv = 1'b1; oe = 1'b0; we = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (req) reqseen = 1'b1;
        end
        #1;
        chk("proto_pulse", 32'(n_pe - pe0), 32'd1);
        chk("proto_noreq", 32'(reqseen), 32'd0);
        oe = 1'b1; we = 1'b1; cs = 1'b1;
        @(negedge clk);

        @(negedge clk);
        cs = 1'b0; adv = 1'b0; ad_i = 16'h0777;
        @(negedge clk);
        adv = 1'b1; oe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rd_req", 32'(req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", 32'(req), 32'd0);
        chk("rst_mid_wait", 32'(wait_o), 32'd0);
        chk("rst_mid_addr", 32'(maddr), 32'd0);
        chk("rst_mid_be", 32'(mbe), 32'd0);
        chk("rst_mid_oe", 32'(ad_oe), 32'd0);
        rst = 1'b0; cs = 1'b1; oe = 1'b1;
        ack = 1'b1; rdata_in = 16'hFFFF;
        @(negedge clk);
        ack = 1'b0;
        chk("late_ack_req", 32'(req), 32'd0);
        chk("late_ack_ad_o", 32'(ad_o), 32'd0);
        do_txn(tbl[0]);

        for (int i = 0; i < 40; i++) begin
            do_txn(model(1'($urandom_range(0, 1)),
                         ($urandom_range(0, 7) == 0),
                         16'($urandom), 16'($urandom),
                         2'($urandom_range(0, 3)),
                         int'($urandom_range(0, 18))));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
